// File: rtl/lpif_tx_arbiter.sv
// lpif_tx_arbiter: whole-packet TLP/DLLP arbiter feeding one registered LPIF beat; request->lp_irdy is 2 cycles.
// Holds the beat while pl_trdy is low; DLLP has priority, with TLP anti-starvation under LPIF_ARB_STARVE_EN.
module lpif_tx_arbiter #(
  parameter int DATA_W     = 512,
  parameter int BYTES      = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              LCLK,
  input  logic              lpreset,
  input  logic              pl_linkUp,
  input  logic [3:0]        pl_state_sts,
  input  logic              pl_trdy,
  input  logic              tlp_req,
  input  logic [DATA_W-1:0] tlp_data,
  input  logic [BYTES-1:0]  tlp_valid,
  input  logic [BYTES-1:0]  tlp_start,
  input  logic [BYTES-1:0]  tlp_end,
  input  logic              tlp_last,
  output logic              tlp_ack,
  input  logic              dlp_req,
  input  logic [DATA_W-1:0] dlp_data,
  input  logic [BYTES-1:0]  dlp_valid,
  input  logic [BYTES-1:0]  dlp_start,
  input  logic [BYTES-1:0]  dlp_end,
  input  logic              dlp_last,
  output logic              dlp_ack,
  output logic              lp_irdy,
  output logic [DATA_W-1:0] lp_data,
  output logic [BYTES-1:0]  lp_valid,
  output logic [BYTES-1:0]  lp_tlpstart,
  output logic [BYTES-1:0]  lp_tlpend,
  output logic [BYTES-1:0]  lp_dlpstart,
  output logic [BYTES-1:0]  lp_dlpend,
  output logic              arb_abort
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_TLP = 2'd1,
    GNT_DLP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  valid;
    logic [BYTES-1:0]  tlpstart;
    logic [BYTES-1:0]  tlpend;
    logic [BYTES-1:0]  dlpstart;
    logic [BYTES-1:0]  dlpend;
  } beat_t;

  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_starve_max_chk
    $error("STARVE_MAX must fit the 3-bit starvation counter");
  end

  state_t state_q, state_d;
  beat_t  beat_q, beat_d;
  logic   lp_irdy_q, lp_irdy_d;
  logic   abort_q, abort_d;
  logic   link_ok;
  logic   slot_free;
  logic   force_tlp;

`ifdef LPIF_ARB_STARVE_EN
  logic [2:0] starve_q, starve_d;

  always_comb begin
    force_tlp = tlp_req && (int'(starve_q) == STARVE_MAX);
    starve_d  = starve_q;
    if (state_q == IDLE && state_d == GNT_TLP) begin
      starve_d = 3'd0;
    end else if (dlp_ack && dlp_last && tlp_req && starve_q != 3'd7) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge LCLK) begin
    if (lpreset) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    force_tlp = 1'b0;
  end
`endif

  always_comb begin
    link_ok   = pl_linkUp && (pl_state_sts == 4'd1);
    slot_free = !lp_irdy_q || pl_trdy;
    tlp_ack   = !lpreset && link_ok && (state_q == GNT_TLP) && tlp_req && slot_free;
    dlp_ack   = !lpreset && link_ok && (state_q == GNT_DLP) && dlp_req && slot_free;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dlp_req && !force_tlp) begin
          state_d = GNT_DLP;
        end else if (tlp_req) begin
          state_d = GNT_TLP;
        end
      end
      GNT_TLP: if (tlp_ack && tlp_last) state_d = IDLE;
      GNT_DLP: if (dlp_ack && dlp_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!link_ok) begin
      state_d = IDLE;
    end

    beat_d    = beat_q;
    lp_irdy_d = lp_irdy_q;
    if (tlp_ack) begin
      beat_d    = '{data: tlp_data, valid: tlp_valid, tlpstart: tlp_start, tlpend: tlp_end,
                    dlpstart: '0, dlpend: '0};
      lp_irdy_d = 1'b1;
    end else if (dlp_ack) begin
      beat_d    = '{data: dlp_data, valid: dlp_valid, tlpstart: '0, tlpend: '0,
                    dlpstart: dlp_start, dlpend: dlp_end};
      lp_irdy_d = 1'b1;
    end else if (pl_trdy) begin
      beat_d    = '0;
      lp_irdy_d = 1'b0;
    end
    // Link loss discards the beat even if the PHY never took it.
    if (!link_ok) begin
      beat_d    = '0;
      lp_irdy_d = 1'b0;
    end
    abort_d = !link_ok && ((state_q != IDLE) || lp_irdy_q);
  end

  always_ff @(posedge LCLK) begin
    if (lpreset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      lp_irdy_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      lp_irdy_q <= lp_irdy_d;
      abort_q   <= abort_d;
    end
  end

  assign lp_irdy     = lp_irdy_q;
  assign lp_data     = beat_q.data;
  assign lp_valid    = beat_q.valid;
  assign lp_tlpstart = beat_q.tlpstart;
  assign lp_tlpend   = beat_q.tlpend;
  assign lp_dlpstart = beat_q.dlpstart;
  assign lp_dlpend   = beat_q.dlpend;
  assign arb_abort   = abort_q;

endmodule

// File: tb/tb_lpif_tx_arbiter.sv
// Bench for lpif_tx_arbiter: directed LPIF scenarios plus randomized packet traffic against a packet-order model.
module tb_lpif_tx_arbiter;
  localparam int DW = 512;
  localparam int BY = 64;

  logic          LCLK = 1'b0;
  logic          lpreset = 1'b1;
  logic          pl_linkUp = 1'b1;
  logic [3:0]    pl_state_sts = 4'd1;
  logic          pl_trdy = 1'b1;
  logic          tlp_req = 1'b0, dlp_req = 1'b0;
  logic [DW-1:0] tlp_data = '0, dlp_data = '0;
  logic [BY-1:0] tlp_valid = '0, tlp_start = '0, tlp_end = '0;
  logic [BY-1:0] dlp_valid = '0, dlp_start = '0, dlp_end = '0;
  logic          tlp_last = 1'b0, dlp_last = 1'b0;
  logic          tlp_ack, dlp_ack, lp_irdy, arb_abort;
  logic [DW-1:0] lp_data;
  logic [BY-1:0] lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [BY-1:0] v, s, e;
    bit            first, last;
  } beat_t;
  typedef struct {
    beat_t b;
    bit    dl;
  } exp_t;

  beat_t tsrc[$], dsrc[$];
  exp_t  expq[$];
  int    xcyc[$];
  bit    obs_dl[$];

  lpif_tx_arbiter dut (
    .LCLK(LCLK), .lpreset(lpreset), .pl_linkUp(pl_linkUp), .pl_state_sts(pl_state_sts),
    .pl_trdy(pl_trdy),
    .tlp_req(tlp_req), .tlp_data(tlp_data), .tlp_valid(tlp_valid), .tlp_start(tlp_start),
    .tlp_end(tlp_end), .tlp_last(tlp_last), .tlp_ack(tlp_ack),
    .dlp_req(dlp_req), .dlp_data(dlp_data), .dlp_valid(dlp_valid), .dlp_start(dlp_start),
    .dlp_end(dlp_end), .dlp_last(dlp_last), .dlp_ack(dlp_ack),
    .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid), .lp_tlpstart(lp_tlpstart),
    .lp_tlpend(lp_tlpend), .lp_dlpstart(lp_dlpstart), .lp_dlpend(lp_dlpend),
    .arb_abort(arb_abort)
  );

  always #5 LCLK = ~LCLK;

  task automatic tick();
    @(posedge LCLK);
    #1;
  endtask

  task automatic add_pkt(input bit dl, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d     = {16{$urandom}};
      b.v     = {$urandom, $urandom};
      b.s     = (i == 0) ? 64'h1 : 64'h0;
      b.e     = (i == len - 1) ? (64'h1 << $urandom_range(63, 0)) : 64'h0;
      b.first = (i == 0);
      b.last  = (i == len - 1);
      if (dl) dsrc.push_back(b);
      else    tsrc.push_back(b);
    end
  endtask

  // Packet-level ordering: DLLP first whenever both have a packet waiting, except that a
  // TLP is forced after four DLLP packets completed while it waited (anti-starvation build).
  task automatic build_expected();
    int   ti, di, cnt;
    bit   pd;
    exp_t x;
    ti = 0; di = 0; cnt = 0;
    expq.delete();
    while (ti < tsrc.size() || di < dsrc.size()) begin
      if (ti < tsrc.size() && di < dsrc.size()) begin
`ifdef LPIF_ARB_STARVE_EN
        pd = (cnt != 4);
`else
        pd = 1'b1;
`endif
      end else begin
        pd = (di < dsrc.size());
      end
      if (pd) begin
        if (ti < tsrc.size() && cnt < 7) cnt++;
        do begin
          x.b = dsrc[di]; x.dl = 1'b1; expq.push_back(x); di++;
        end while (!dsrc[di-1].last);
      end else begin
        cnt = 0;
        do begin
          x.b = tsrc[ti]; x.dl = 1'b0; expq.push_back(x); ti++;
        end while (!tsrc[ti-1].last);
      end
    end
  endtask

  // Sources keep the first beat of each packet requested; later beats may gap randomly.
  task automatic run_traffic(input bit gaps, input bit trdy_rand);
    int            ti, di, oi, guard;
    logic [BY-1:0] ets, ete, eds, ede;
    ti = 0; di = 0; oi = 0; guard = 0;
    xcyc.delete();
    obs_dl.delete();
    build_expected();
    while (oi < expq.size() && guard < 3000) begin
      if (ti < tsrc.size()) begin
        tlp_req  = tsrc[ti].first || !gaps || ($urandom_range(3, 0) != 0);
        tlp_data = tsrc[ti].d; tlp_valid = tsrc[ti].v; tlp_start = tsrc[ti].s;
        tlp_end  = tsrc[ti].e; tlp_last = tsrc[ti].last;
      end else begin
        tlp_req = 1'b0;
      end
      if (di < dsrc.size()) begin
        dlp_req  = dsrc[di].first || !gaps || ($urandom_range(3, 0) != 0);
        dlp_data = dsrc[di].d; dlp_valid = dsrc[di].v; dlp_start = dsrc[di].s;
        dlp_end  = dsrc[di].e; dlp_last = dsrc[di].last;
      end else begin
        dlp_req = 1'b0;
      end
      pl_trdy = !trdy_rand || ($urandom_range(2, 0) != 0);
      @(negedge LCLK);
      if (tlp_ack || dlp_ack) begin
        n_chk++;
        if ((tlp_ack && !tlp_req) || (dlp_ack && !dlp_req) || (tlp_ack && dlp_ack)) begin
          n_err++;
          $display("FAIL ack_qual: got tlp_ack=%0b dlp_ack=%0b with tlp_req=%0b dlp_req=%0b, want ack only with own req",
                   tlp_ack, dlp_ack, tlp_req, dlp_req);
        end
        if (tlp_ack) ti++;
        if (dlp_ack) di++;
      end
      if (lp_irdy && pl_trdy) begin
        ets = expq[oi].dl ? '0 : expq[oi].b.s;
        ete = expq[oi].dl ? '0 : expq[oi].b.e;
        eds = expq[oi].dl ? expq[oi].b.s : '0;
        ede = expq[oi].dl ? expq[oi].b.e : '0;
        n_chk++;
        if (lp_data !== expq[oi].b.d || lp_valid !== expq[oi].b.v || lp_tlpstart !== ets ||
            lp_tlpend !== ete || lp_dlpstart !== eds || lp_dlpend !== ede) begin
          n_err++;
          $display("FAIL beat%0d: got d=%h v=%h ts=%h te=%h ds=%h de=%h want d=%h v=%h ts=%h te=%h ds=%h de=%h",
                   oi, lp_data[31:0], lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend,
                   expq[oi].b.d[31:0], expq[oi].b.v, ets, ete, eds, ede);
        end
        if (lp_tlpstart != '0) obs_dl.push_back(1'b0);
        if (lp_dlpstart != '0) obs_dl.push_back(1'b1);
        xcyc.push_back(guard);
        oi++;
      end
      tick();
      guard++;
    end
    n_chk++;
    if (oi != expq.size()) begin
      n_err++;
      $display("FAIL traffic_timeout: got %0d beats, want %0d", oi, expq.size());
    end
    tlp_req = 1'b0; dlp_req = 1'b0; pl_trdy = 1'b1;
    tick(); tick();
    tsrc.delete(); dsrc.delete();
  endtask

  task automatic test_reset();
    lpreset = 1'b1; tlp_req = 1'b1; dlp_req = 1'b1;
    tick(); tick();
    @(negedge LCLK);
    n_chk++;
    if (tlp_ack !== 1'b0 || dlp_ack !== 1'b0 || lp_irdy !== 1'b0 || arb_abort !== 1'b0 ||
        lp_data !== '0 || lp_valid !== '0 || lp_tlpstart !== '0 || lp_dlpstart !== '0 ||
        lp_tlpend !== '0 || lp_dlpend !== '0) begin
      n_err++;
      $display("FAIL reset: got acks=%0b%0b irdy=%0b abort=%0b data=%h, want all 0",
               tlp_ack, dlp_ack, lp_irdy, arb_abort, lp_data[31:0]);
    end
    tick();
    tlp_req = 1'b0; dlp_req = 1'b0; lpreset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    tlp_req = 1'b1; tlp_data = {64{8'hA5}}; tlp_valid = '1; tlp_start = 64'h1;
    tlp_end = 64'h1 << 63; tlp_last = 1'b1;
    @(negedge LCLK);
    n_chk++;
    if (tlp_ack !== 1'b0) begin
      n_err++; $display("FAIL single_c0_ack: got %0b want 0", tlp_ack);
    end
    tick();
    @(negedge LCLK);
    n_chk++;
    if (tlp_ack !== 1'b1) begin
      n_err++; $display("FAIL single_c1_ack: got %0b want 1", tlp_ack);
    end
    tick();
    tlp_req = 1'b0;
    @(negedge LCLK);
    n_chk++;
    if (lp_irdy !== 1'b1 || lp_tlpstart[0] !== 1'b1 || lp_data !== {64{8'hA5}} ||
        lp_tlpend !== (64'h1 << 63) || lp_dlpstart !== '0) begin
      n_err++;
      $display("FAIL single_c2: got irdy=%0b ts=%h te=%h ds=%h d=%h, want 1/1/8000../0/a5a5a5a5",
               lp_irdy, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_data[31:0]);
    end
    tick();
    @(negedge LCLK);
    n_chk++;
    if (lp_irdy !== 1'b0 || lp_data !== '0) begin
      n_err++; $display("FAIL single_c3: got irdy=%0b d=%h want 0/0", lp_irdy, lp_data[31:0]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] bd [3];
    int idx, got;
    idx = 0; got = 0;
    for (int i = 0; i < 3; i++) bd[i] = {16{$urandom}};
    for (int c = 0; c < 8; c++) begin
      tlp_req   = (idx < 3);
      tlp_data  = bd[(idx < 3) ? idx : 2];
      tlp_valid = '1;
      tlp_start = (idx == 0) ? 64'h1 : 64'h0;
      tlp_end   = (idx == 2) ? 64'h1 : 64'h0;
      tlp_last  = (idx == 2);
      pl_trdy   = !(c == 3 || c == 4);
      @(negedge LCLK);
      if (c == 3 || c == 4) begin
        n_chk++;
        if (lp_irdy !== 1'b1 || lp_data !== bd[1] || tlp_ack !== 1'b0) begin
          n_err++;
          $display("FAIL bp_hold_c%0d: got irdy=%0b d=%h ack=%0b want 1/%h/0",
                   c, lp_irdy, lp_data[31:0], tlp_ack, bd[1][31:0]);
        end
      end
      if (lp_irdy && pl_trdy) begin
        n_chk++;
        if (got > 2 || lp_data !== bd[(got > 2) ? 2 : got]) begin
          n_err++; $display("FAIL bp_order%0d: got d=%h", got, lp_data[31:0]);
        end
        got++;
      end
      if (tlp_ack) idx++;
      tick();
    end
    tlp_req = 1'b0; pl_trdy = 1'b1;
    n_chk++;
    if (got != 3) begin
      n_err++; $display("FAIL bp_count: got %0d beats want 3", got);
    end
    tick();
  endtask

  task automatic test_tie();
    add_pkt(1'b1, 1);
    add_pkt(1'b0, 1);
    run_traffic(1'b0, 1'b0);
    n_chk++;
    if (xcyc.size() != 2 || obs_dl.size() != 2 || obs_dl[0] !== 1'b1 || xcyc[1] - xcyc[0] != 2) begin
      n_err++;
      $display("FAIL tie_order: got %0d beats, first_dlp=%0b, gap=%0d, want 2 beats, dlp first, gap 2",
               xcyc.size(), (obs_dl.size() > 0) ? obs_dl[0] : 1'b0,
               (xcyc.size() == 2) ? xcyc[1] - xcyc[0] : -1);
    end
  endtask

  task automatic test_linkloss();
    logic [DW-1:0] nd;
    int aborts;
    aborts = 0;
    nd = {16{$urandom}};
    tlp_valid = '1; tlp_end = '0; tlp_last = 1'b0;
    tlp_req = 1'b1; tlp_data = {16{32'h1}}; tlp_start = 64'h1;
    tick();
    tlp_data = {16{32'h2}}; tlp_start = '0;
    tick();
    tlp_data = {16{32'h3}};
    tick();
    tlp_data = {16{32'h4}}; pl_linkUp = 1'b0;
    @(negedge LCLK);
    n_chk++;
    if (tlp_ack !== 1'b0 || arb_abort !== 1'b0) begin
      n_err++; $display("FAIL ll_drop: got ack=%0b abort=%0b want 0/0", tlp_ack, arb_abort);
    end
    tick();
    @(negedge LCLK);
    n_chk++;
    if (arb_abort !== 1'b1 || lp_irdy !== 1'b0 || tlp_ack !== 1'b0 || lp_data !== '0) begin
      n_err++;
      $display("FAIL ll_abort: got abort=%0b irdy=%0b ack=%0b d=%h want 1/0/0/0",
               arb_abort, lp_irdy, tlp_ack, lp_data[31:0]);
    end
    if (arb_abort) aborts++;
    tick();
    pl_linkUp = 1'b1; tlp_data = nd; tlp_start = 64'h1; tlp_end = 64'h2; tlp_last = 1'b1;
    @(negedge LCLK);
    n_chk++;
    if (arb_abort !== 1'b0 || tlp_ack !== 1'b0) begin
      n_err++; $display("FAIL ll_restore: got abort=%0b ack=%0b want 0/0", arb_abort, tlp_ack);
    end
    if (arb_abort) aborts++;
    tick();
    @(negedge LCLK);
    n_chk++;
    if (tlp_ack !== 1'b1) begin
      n_err++; $display("FAIL ll_regrant: got ack=%0b want 1", tlp_ack);
    end
    if (arb_abort) aborts++;
    tick();
    tlp_req = 1'b0;
    @(negedge LCLK);
    n_chk++;
    if (lp_irdy !== 1'b1 || lp_data !== nd || aborts != 1) begin
      n_err++;
      $display("FAIL ll_newbeat: got irdy=%0b d=%h aborts=%0d want 1/%h/1",
               lp_irdy, lp_data[31:0], aborts, nd[31:0]);
    end
    tick(); tick();
  endtask

  task automatic test_not_active();
    pl_state_sts = 4'd0; tlp_req = 1'b1; dlp_req = 1'b1; tlp_last = 1'b1; dlp_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge LCLK);
      n_chk++;
      if (tlp_ack !== 1'b0 || dlp_ack !== 1'b0 || lp_irdy !== 1'b0 || arb_abort !== 1'b0) begin
        n_err++;
        $display("FAIL not_active_c%0d: got acks=%0b%0b irdy=%0b abort=%0b want all 0",
                 c, tlp_ack, dlp_ack, lp_irdy, arb_abort);
      end
      tick();
    end
    tlp_req = 1'b0; dlp_req = 1'b0; pl_state_sts = 4'd1;
    tick();
  endtask

  task automatic test_starve();
    int lead;
    lead = 0;
    for (int i = 0; i < 6; i++) add_pkt(1'b1, 1 + (i % 2));
    add_pkt(1'b0, 2);
    add_pkt(1'b0, 1);
    run_traffic(1'b0, 1'b0);
    while (lead < obs_dl.size() && obs_dl[lead]) lead++;
    n_chk++;
`ifdef LPIF_ARB_STARVE_EN
    if (lead != 4 || obs_dl.size() != 8 || obs_dl[5] !== 1'b1) begin
      n_err++; $display("FAIL starve: got %0d DLLPs before first TLP want 4, then DLLP resume", lead);
    end
`else
    if (lead != 6 || obs_dl.size() != 8) begin
      n_err++; $display("FAIL strict_prio: got %0d DLLPs before first TLP want 6", lead);
    end
`endif
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = $urandom_range(6, 2); i > 0; i--) add_pkt(1'b1, $urandom_range(3, 1));
      for (int i = $urandom_range(6, 2); i > 0; i--) add_pkt(1'b0, $urandom_range(6, 1));
      run_traffic(1'b1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_tie();
    test_linkloss();
    test_not_active();
    test_starve();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lpif_tx_arbiter.md
# lpif_tx_arbiter

Shares the LPIF transmit datapath (lp_irdy/lp_data/lp_valid/start/end markers) between two packet sources: the TLP path and the DLLP path of the link layer. It grants whole packets, registers one outgoing beat, and honours the PHY's pl_trdy backpressure. It blocks all traffic unless the link is up and the LTSSM reports Active. It sits between the link-layer transmit engines and the LPIF boundary.

## Interface
Parameters:
- DATA_W, 512, LPIF data width in bits
- BYTES, 64, DATA_W/8; width of the per-byte valid and marker vectors
- STARVE_MAX, 4, consecutive DLLP packets allowed before a pending TLP is forced (only with LPIF_ARB_STARVE_EN)

Ports:
- LCLK  in  1  clock
- lpreset  in  1  synchronous active-high reset
- pl_linkUp  in  1  link up from PHY
- pl_state_sts  in  4  LTSSM status; 4'd1 = Active
- pl_trdy  in  1  PHY accepts the current beat
- tlp_req  in  1  TLP source has a beat
- tlp_data  in  DATA_W  TLP beat data
- tlp_valid, tlp_start, tlp_end  in  BYTES  per-byte valid, TLP start marker and TLP end marker
- tlp_last  in  1  last beat of the TLP packet
- tlp_ack  out  1  beat consumed this cycle
- dlp_req, dlp_data, dlp_valid, dlp_start, dlp_end, dlp_last, dlp_ack: same as the TLP set, for DLLPs
- lp_irdy  out  1  beat valid to PHY
- lp_data  out  DATA_W  beat data
- lp_valid  out  BYTES  per-byte valid
- lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend  out  BYTES  per-byte start/end markers
- arb_abort  out  1  one-cycle pulse when a packet is cut off by link loss

## Operation
- link_ok = pl_linkUp && (pl_state_sts == 4'd1).
- FSM states: IDLE, GNT_TLP, GNT_DLP.
- IDLE, when link_ok:
  - dlp_req has priority and moves the FSM to GNT_DLP.
  - Otherwise tlp_req moves the FSM to GNT_TLP.
  - With no request, the FSM stays in IDLE.
- GNT_x:
  - slot_free = !lp_irdy || pl_trdy.
  - x_ack = x_req && slot_free. It is combinational and is never asserted in IDLE.
  - A beat with x_ack high is loaded into the output register.
  - A beat with x_ack && x_last returns the FSM to IDLE. The next grant is decided in IDLE, so there is one bubble cycle per packet boundary.
- Output register:
  - TLP beats load lp_tlpstart/lp_tlpend from tlp_start/tlp_end and drive the DLP markers to zero.
  - DLLP beats do the reverse.
- Per cycle, the output register behaves as follows:
  - lp_irdy is set when a beat loads.
  - If pl_trdy is high and no beat loads, lp_irdy clears and all outputs zero.
  - If pl_trdy is low, all outputs hold.
- Mid-packet gaps (x_req low while granted) are allowed. The grant is held and lp_irdy drops once the held beat drains.
- Link loss (!link_ok) in any state:
  - The next edge forces IDLE and clears lp_irdy and all lp_* outputs, even if the beat was undelivered.
  - arb_abort pulses for one cycle if the state was GNT_x or lp_irdy was high.
  - No ack is issued while !link_ok.

## Timing
- Reset (lpreset high at an LCLK edge): FSM to IDLE.
  - lp_irdy, lp_data, lp_valid, all markers, arb_abort = 0.
  - The starvation count is cleared.
  - Acks are 0 during reset.
- Latency:
  - Cycle 0: request in IDLE.
  - Cycle 1: GNT_x and the first ack.
  - Cycle 2: lp_irdy high with that beat.
- Throughput is one beat per cycle while pl_trdy is held high.
- A beat is transferred to the PHY on any edge where lp_irdy && pl_trdy.
- Both requests arriving in IDLE in the same cycle: DLLP wins (see Configuration).
- link_ok dropping in the same cycle as a final ack: the abort wins. The ack is suppressed and arb_abort pulses.

## Configuration
- LPIF_ARB_STARVE_EN defined:
  - A 3-bit counter increments on every DLLP packet completion made while tlp_req is high.
  - The counter clears on any TLP grant.
  - When the count equals STARVE_MAX and tlp_req is high in IDLE, GNT_TLP is taken even if dlp_req is high.
- LPIF_ARB_STARVE_EN undefined: the counter is absent and DLLP strict priority applies.

## Test plan
- Reset, then a single-beat TLP (tlp_req, tlp_last=1, data 'hA5..) with pl_trdy=1 and link Active:
  - tlp_ack in cycle 1.
  - lp_irdy=1 with lp_tlpstart[0]=1 in cycle 2.
  - lp_irdy=0 in cycle 3.
- A 3-beat TLP with pl_trdy held low for 2 cycles at beat 2:
  - lp_data holds beat 2 for those cycles and tlp_ack stays low.
  - All 3 beats arrive in order.
- tlp_req and dlp_req asserted together in IDLE:
  - The DLLP is sent first with lp_dlpstart/lp_dlpend set and TLP markers at 0.
  - The TLP follows after one bubble cycle.
- pl_linkUp drops during beat 2 of a 4-beat TLP:
  - arb_abort pulses once and lp_irdy = 0 next cycle.
  - No acks while the link is down.
  - After the link is restored, a new grant occurs.
- pl_state_sts = 4'd0 with requests pending: no ack and lp_irdy stays 0.
- With LPIF_ARB_STARVE_EN, continuous dlp_req plus tlp_req, STARVE_MAX=4: exactly 4 DLLP packets, then 1 TLP, then DLLPs resume.
- Without LPIF_ARB_STARVE_EN, the same stimulus: the TLP is never granted while dlp_req is held.
